syscall_io_ctrl: RTL and testbench

Executes the two SYSCALL opcodes for the single-cycle core. It sits beside the control decoder, takes the raw instruction opcode and the register-file read port, and drives the core-wide clock enable. For SYSCALL-input it freezes the core until the user sets switches and presses a debounced confirm button, then supplies the switch value for register write-back. For SYSCALL-output it latches a register value for the 7-segment display driver.

---
 rtl/syscall_io_ctrl.sv | 147 ++++++++++++++
 tb/tb_syscall_io_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_io_ctrl.sv
// SYSCALL input/output execution unit: stalls the core for switch input
// confirmed by a debounced button, and latches register values for the display.
module syscall_io_ctrl #(
   parameter int DATA_W          = 32,
   parameter int SW_W            = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        op,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [SW_W-1:0]   sw,
   input  logic              btn_confirm,
   output logic              core_en,
   output logic [DATA_W-1:0] in_data,
   output logic              in_valid,
   output logic [DATA_W-1:0] disp_value,
   output logic              disp_valid,
   output logic              busy
);

   localparam logic [5:0] OP_INPUT  = 6'b110011;
   localparam logic [5:0] OP_OUTPUT = 6'b110111;
   localparam int         CNT_W     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_PRESS,
      WAIT_RELEASE,
      COMMIT
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        btn_sync_q;
   logic [SW_W-1:0]   sw_sync1_q, sw_sync2_q;
   logic              btn_stable_q, btn_stable_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] in_data_q, in_data_d;
   logic [DATA_W-1:0] disp_value_q, disp_value_d;
   logic              disp_valid_q, disp_valid_d;

   logic btn_s;
   logic btn_differ;
   logic btn_flip;
   logic btn_press;
   logic btn_release;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_sync_q <= '0;
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
      end else begin
         btn_sync_q <= {btn_sync_q[0], btn_confirm};
         sw_sync1_q <= sw;
         sw_sync2_q <= sw_sync1_q;
      end
   end

   // Counter tracks consecutive cycles the synchronized button disagrees with
   // the accepted level; any agreeing cycle discards a partial bounce.
   always_comb begin
      btn_s        = btn_sync_q[1];
      btn_differ   = btn_s ^ btn_stable_q;
      btn_flip     = btn_differ && (cnt_q == CNT_MAX);
      btn_press    = btn_flip && btn_s;
      btn_release  = btn_flip && !btn_s;
      btn_stable_d = btn_stable_q;
      cnt_d        = '0;
      if (btn_flip) begin
         btn_stable_d = btn_s;
      end else if (btn_differ) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_stable_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         btn_stable_q <= btn_stable_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      in_data_d    = in_data_q;
      disp_value_d = disp_value_q;
      disp_valid_d = disp_valid_q;
      case (state_q)
         IDLE: begin
            if (op == OP_INPUT) begin
               state_d = WAIT_PRESS;
            end else if (op == OP_OUTPUT) begin
               disp_value_d = rs_data;
               disp_valid_d = 1'b1;
            end
         end
         WAIT_PRESS: begin
            if (btn_press) begin
               in_data_d = DATA_W'(sw_sync2_q);
               state_d   = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (btn_release) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         in_data_q    <= '0;
         disp_value_q <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_data_q    <= in_data_d;
         disp_value_q <= disp_value_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   // The stall must take effect in the same cycle INPUT is decoded so the PC holds.
   always_comb begin
      busy    = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
      core_en = !(busy || ((state_q == IDLE) && (op == OP_INPUT)));
   end

   assign in_valid   = (state_q == COMMIT);
   assign in_data    = in_data_q;
   assign disp_value = disp_value_q;
   assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_syscall_io_ctrl.sv
// Self-checking bench for syscall_io_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural model.
module tb_syscall_io_ctrl;

   localparam int DATA_W = 32;
   localparam int SW_W   = 16;
   localparam int DEB    = 4;
   localparam logic [5:0] OP_IN  = 6'b110011;
   localparam logic [5:0] OP_OUT = 6'b110111;

   localparam int M_IDLE    = 0;
   localparam int M_PRESS   = 1;
   localparam int M_RELEASE = 2;
   localparam int M_COMMIT  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [5:0]        op;
   logic [DATA_W-1:0] rs_data;
   logic [SW_W-1:0]   sw;
   logic              btn_confirm;
   logic              core_en;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic [DATA_W-1:0] disp_value;
   logic              disp_valid;
   logic              busy;

   int errorCount = 0;
   int checkCount = 0;

   // Behavioural model: synchronizers as 2-deep delay lines, debouncer as a
   // sliding window of the last DEB synchronized samples.
   int          mMode;
   logic [31:0] mInData;
   logic [31:0] mDisp;
   logic        mDispValid;
   bit          mStable;
   bit          btnP0, btnP1;
   logic [15:0] swP0, swP1;
   bit          btnHist[$];

   syscall_io_ctrl #(
      .DATA_W(DATA_W),
      .SW_W(SW_W),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .op(op),
      .rs_data(rs_data),
      .sw(sw),
      .btn_confirm(btn_confirm),
      .core_en(core_en),
      .in_data(in_data),
      .in_valid(in_valid),
      .disp_value(disp_value),
      .disp_valid(disp_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task modelReset();
      mMode      = M_IDLE;
      mInData    = '0;
      mDisp      = '0;
      mDispValid = 1'b0;
      mStable    = 1'b0;
      btnP0      = 1'b0;
      btnP1      = 1'b0;
      swP0       = '0;
      swP1       = '0;
      btnHist.delete();
   endtask

   task modelAdvance();
      bit allDiff;
      bit pressEv;
      bit releaseEv;
      btnHist.push_back(btnP1);
      if (btnHist.size() > DEB) void'(btnHist.pop_front());
      allDiff = (btnHist.size() == DEB);
      foreach (btnHist[k]) if (btnHist[k] == mStable) allDiff = 1'b0;
      pressEv   = allDiff && !mStable;
      releaseEv = allDiff && mStable;
      if (allDiff) mStable = ~mStable;
      case (mMode)
         M_IDLE: begin
            if (op == OP_IN) mMode = M_PRESS;
            else if (op == OP_OUT) begin
               mDisp      = rs_data;
               mDispValid = 1'b1;
            end
         end
         M_PRESS: if (pressEv) begin
            mInData = {16'h0000, swP1};
            mMode   = M_RELEASE;
         end
         M_RELEASE: if (releaseEv) mMode = M_COMMIT;
         default: mMode = M_IDLE;
      endcase
      btnP1 = btnP0;
      btnP0 = btn_confirm;
      swP1  = swP0;
      swP0  = sw;
   endtask

   task checkAll();
      bit expStall;
      expStall = (mMode == M_PRESS) || (mMode == M_RELEASE) || ((mMode == M_IDLE) && (op == OP_IN));
      checkOutput("core_en", {31'b0, core_en}, {31'b0, !expStall});
      checkOutput("in_valid", {31'b0, in_valid}, {31'b0, mMode == M_COMMIT});
      checkOutput("busy", {31'b0, busy}, {31'b0, (mMode == M_PRESS) || (mMode == M_RELEASE)});
      checkOutput("in_data", in_data, mInData);
      checkOutput("disp_value", disp_value, mDisp);
      checkOutput("disp_valid", {31'b0, disp_valid}, {31'b0, mDispValid});
   endtask

   // One clock: drive at the falling edge, check before the rising edge,
   // then advance the model and let DUT registers settle.
   task applyStimulus(input logic [5:0] o, input logic [31:0] r, input logic [15:0] s, input logic b);
      @(negedge clk);
      op          = o;
      rs_data     = r;
      sw          = s;
      btn_confirm = b;
      #1;
      checkAll();
      @(posedge clk);
      if (rst_n) modelAdvance();
      else modelReset();
      #1;
   endtask

   initial begin
      int firstIdx;
      int validCount;
      int validIdx;
      bit commitSeen;
      logic [5:0] rop;
      int segLeft;
      logic rbtn;

      rst_n = 1'b0;
      op = '0;
      rs_data = '0;
      sw = '0;
      btn_confirm = 1'b0;
      modelReset();
      $display("[TB] reset");
      for (int i = 0; i < 3; i++) applyStimulus(6'd0, 32'h0, 16'h0, 1'b0);
      checkOutput("rst_core_en", {31'b0, core_en}, 32'd1);
      checkOutput("rst_in_valid", {31'b0, in_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_disp_valid", {31'b0, disp_valid}, 32'd0);
      checkOutput("rst_disp_value", disp_value, 32'd0);
      checkOutput("rst_in_data", in_data, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) applyStimulus(6'd0, 32'h0, 16'h00A5, 1'b0);

      $display("[TB] input syscall");
      applyStimulus(OP_IN, 32'h0, 16'h00A5, 1'b0);
      checkOutput("in_busy_first", {31'b0, busy}, 32'd1);
      checkOutput("in_core_en_first", {31'b0, core_en}, 32'd0);
      firstIdx = 0;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(OP_IN, 32'h0, 16'h00A5, 1'b1);
         if (firstIdx == 0 && in_data == 32'h000000A5) firstIdx = i;
      end
      checkOutput("press_latency", firstIdx, 32'd6);
      checkOutput("press_in_data", in_data, 32'h000000A5);
      validCount = 0;
      validIdx = 0;
      commitSeen = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(commitSeen ? 6'd0 : OP_IN, 32'h0, 16'h00A5, 1'b0);
         if (in_valid) begin
            validCount++;
            if (validIdx == 0) validIdx = i;
            checkOutput("commit_core_en", {31'b0, core_en}, 32'd1);
            commitSeen = 1'b1;
         end
      end
      checkOutput("release_latency", validIdx, 32'd6);
      checkOutput("commit_once", validCount, 32'd1);
      checkOutput("back_idle_busy", {31'b0, busy}, 32'd0);

      $display("[TB] bounce");
      applyStimulus(OP_IN, 32'h0, 16'h1234, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(6'd0, 32'h0, 16'h1234, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(6'd0, 32'h0, 16'h1234, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(6'd0, 32'h0, 16'h1234, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(6'd0, 32'h0, 16'h1234, 1'b0);
      checkOutput("bounce_in_data", in_data, 32'h000000A5);
      checkOutput("bounce_busy", {31'b0, busy}, 32'd1);
      for (int i = 0; i < 10; i++) applyStimulus(6'd0, 32'h0, 16'h0F0F, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(6'd0, 32'h0, 16'h0F0F, 1'b0);
      checkOutput("bounce_exit_data", in_data, 32'h00000F0F);

      $display("[TB] output syscall");
      applyStimulus(OP_OUT, 32'hDEADBEEF, 16'h0, 1'b0);
      checkOutput("out_disp_value", disp_value, 32'hDEADBEEF);
      checkOutput("out_disp_valid", {31'b0, disp_valid}, 32'd1);
      checkOutput("out_core_en", {31'b0, core_en}, 32'd1);
      applyStimulus(6'd0, 32'h12345678, 16'h0, 1'b0);
      checkOutput("out_hold", disp_value, 32'hDEADBEEF);

      $display("[TB] held button");
      for (int i = 0; i < 10; i++) applyStimulus(6'd0, 32'h0, 16'h1111, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(OP_IN, 32'h0, (i < 5) ? 16'h1111 : 16'h2222, 1'b1);
      checkOutput("held_no_capture", in_data, 32'h00000F0F);
      for (int i = 0; i < 10; i++) applyStimulus(6'd0, 32'h0, 16'h2222, 1'b0);
      checkOutput("held_release_busy", {31'b0, busy}, 32'd1);
      checkOutput("held_release_data", in_data, 32'h00000F0F);
      for (int i = 0; i < 10; i++) applyStimulus(6'd0, 32'h0, 16'h2222, 1'b1);
      checkOutput("held_new_capture", in_data, 32'h00002222);
      for (int i = 0; i < 10; i++) applyStimulus(6'd0, 32'h0, 16'h2222, 1'b0);

      $display("[TB] reset mid-wait");
      applyStimulus(OP_IN, 32'h0, 16'h3333, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(OP_IN, 32'h0, 16'h3333, 1'b1);
      checkOutput("midwait_data", in_data, 32'h00003333);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
      checkOutput("midrst_in_data", in_data, 32'd0);
      checkOutput("midrst_disp", disp_value, 32'd0);
      checkOutput("midrst_core_en", {31'b0, core_en}, 32'd0);
      for (int i = 0; i < 2; i++) applyStimulus(OP_IN, 32'h0, 16'h3333, 1'b1);
      rst_n = 1'b1;
      applyStimulus(OP_IN, 32'h0, 16'h3333, 1'b1);
      checkOutput("postrst_core_en", {31'b0, core_en}, 32'd0);
      checkOutput("postrst_busy", {31'b0, busy}, 32'd1);
      for (int i = 0; i < 10; i++) applyStimulus(6'd0, 32'h0, 16'h0, 1'b0);

      $display("[TB] random");
      segLeft = 0;
      rbtn = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (segLeft == 0) begin
            rbtn = ~rbtn;
            segLeft = $urandom_range(9, 1);
         end
         segLeft--;
         case ($urandom_range(9, 0))
            0, 1: rop = OP_IN;
            2: rop = OP_OUT;
            default: begin
               rop = 6'($urandom);
               if (rop == OP_IN || rop == OP_OUT) rop = 6'd0;
            end
         endcase
         applyStimulus(rop, $urandom, 16'($urandom), rbtn);
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
